regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-read-port general-purpose register file for the pipelined MIPS core.
//  Adds write-to-read bypass, an optional hard-wired zero register, and a pending-write scoreboard.
//  Decode reads operands and hazard status here in one cycle; writeback retires results.
//  Sits between the decode and writeback stages; replaces the single-cycle 2-read file.
// PARAMETERS
//  DW        32  data width of each register
//  DEPTH     32  number of registers (power of two, >=2)
//  AW        5   address width, = log2(DEPTH)
//  NR        2   number of read ports (1..4)
//  ZERO_REG  1   1: register 0 reads 0, ignores writes and never becomes pending
//  BYPASS    1   1: same-cycle writeback data is forwarded to matching read ports
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  wr_en        in   1      writeback strobe
//  wr_addr      in   AW     writeback destination
//  wr_data      in   DW     writeback value
//  issue_en     in   1      decode issued an instruction that will write issue_addr
//  issue_addr   in   AW     destination of the issued instruction
//  flush        in   1      pipeline flush: clear all pending bits
//  rd_addr      in   NR*AW  packed read addresses; port k = [k*AW +: AW]
//  rd_data      out  NR*DW  packed read data; port k = [k*DW +: DW]
//  rd_pending   out  NR     port k operand has an outstanding unretired write
//  sb_empty     out  1      no register pending (safe to drain or switch context)
// BEHAVIOUR
//  - Reset (rst_n low, async): all registers 0; all pending bits 0; sb_empty=1.
//    rd_data reflects the zeroed storage immediately.
//  - Write: on posedge, if wr_en, reg[wr_addr] <= wr_data.
//    Dropped when ZERO_REG=1 and wr_addr==0.
//  - Read: combinational, zero latency.
//    rd_data[k] = 0 if ZERO_REG and rd_addr[k]==0.
//    Else, if BYPASS and wr_en and wr_addr==rd_addr[k], rd_data[k] = wr_data.
//    Else rd_data[k] = reg[rd_addr[k]].
//  - All NR ports are independent; the same address on several ports gives the same data.
//  - Scoreboard: one pending bit per register, pend[DEPTH-1:0], updated on posedge.
//    Priority per bit, highest first:
//      1. issue_en && issue_addr==i && !(ZERO_REG && i==0)    -> pend[i] <= 1
//      2. flush                                                -> pend[i] <= 0
//      3. wr_en && wr_addr==i                                  -> pend[i] <= 0
//      4. otherwise hold
//    Simultaneous issue and writeback to the same register leaves it pending (new producer).
//    Issue during flush is kept: the issuing instruction is the first after the flush.
//  - rd_pending[k] = pend[rd_addr[k]] & ~(BYPASS && wr_en && wr_addr==rd_addr[k]).
//    Forced 0 for address 0 when ZERO_REG.
//    When BYPASS=0, a register being written this cycle still reports pending.
//  - sb_empty = ~|pend (registered state, not the next state).
//  - Reset mid-operation: storage and scoreboard clear at once.
//    In-flight issue/writeback in that cycle is lost.
//  - Out-of-range parameters (NR>4, DEPTH != 2**AW) are stopped by an elaboration-time check.
// STRUCTURE
//  - Shared package cpu_pkg: REG_ZERO=0, REG_RA=31, default DW/AW localparams.
//    The top-level core instance uses these defaults.
//  - Sub-module regfile_scoreboard (DEPTH, AW, ZERO_REG):
//    holds pend[], applies the set/clear priority, drives sb_empty,
//    and provides the pend vector for rd_pending lookup.
//  - Storage, read muxes and bypass stay in regfile_sb; read ports come from a generate loop over NR.
// TESTING
//  1. Reset: write 0xDEADBEEF to r5, then pulse rst_n low mid-cycle
//     -> r5 reads 0 without waiting for a clock edge, sb_empty=1.
//  2. Zero reg: wr_en, wr_addr=0, wr_data=0xFFFFFFFF; issue_addr=0
//     -> r0 reads 0 on all ports, rd_pending=0, sb_empty stays 1.
//  3. Bypass: write r7=0x12345678, then in one cycle write r7=0xCAFEF00D with rd_addr0=rd_addr1=7
//     -> both ports read 0xCAFEF00D that cycle.
//     With BYPASS=0 they read 0x12345678 that cycle and 0xCAFEF00D after the edge.
//  4. Scoreboard: issue r9; next cycle rd_addr=9 -> rd_pending=1, sb_empty=0.
//     Writeback r9=0x55 -> rd_pending=0 that cycle, data 0x55; sb_empty=1 after the edge.
//  5. Same-cycle issue+writeback r3 -> r3 still pending after the edge.
//     flush with issue r4 -> only r4 pending.
//  6. NR=4, DEPTH=16, DW=16: random writes and 4 concurrent reads vs a reference model over 10k cycles
//     -> zero mismatches.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core constants: architectural register numbers and default datapath sizes.
// Also holds the parameter sanity check used by the register file at elaboration.
package cpu_pkg;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;
    localparam int CPU_DW   = 32;
    localparam int CPU_AW   = 5;
    localparam int MAX_NR   = 4;

    // True when the read-port count is supported and DEPTH exactly fills the address space.
    function automatic bit rf_params_ok(int depth, int aw, int nr);
        return (nr >= 1) && (nr <= MAX_NR) && (aw >= 1) && (aw < 31) && (depth == (1 << aw));
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue and cleared at writeback or flush.
// An issue always wins so the newest producer of a register is never lost.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int AW       = CPU_AW,
    parameter bit ZERO_REG = 1'b1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic             issue_en_i,
    input  logic [AW-1:0]    issue_addr_i,
    input  logic             flush_i,
    output logic [DEPTH-1:0] pend_o,
    output logic             sb_empty_o
);

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (issue_en_i && (issue_addr_i == AW'(i)) && !(ZERO_REG && (i == REG_ZERO))) begin
                pend_d[i] = 1'b1;
            end else if (flush_i) begin
                pend_d[i] = 1'b0;
            end else if (wr_en_i && (wr_addr_i == AW'(i))) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_o     = pend_q;
    assign sb_empty_o = ~|pend_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with writeback bypass, optional hard-wired r0
// and a pending-write scoreboard for decode-stage hazard detection.
module regfile_sb
    import cpu_pkg::*;
#(
    parameter int DW       = CPU_DW,
    parameter int DEPTH    = 32,
    parameter int AW       = CPU_AW,
    parameter int NR       = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DW-1:0]    wr_data,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_addr,
    input  logic             flush,
    input  logic [NR*AW-1:0] rd_addr,
    output logic [NR*DW-1:0] rd_data,
    output logic [NR-1:0]    rd_pending,
    output logic             sb_empty
);

    generate
        if (!rf_params_ok(DEPTH, AW, NR)) begin : g_bad_params
            $error("regfile_sb: unsupported parameters DEPTH=%0d AW=%0d NR=%0d", DEPTH, AW, NR);
        end
    endgenerate

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DEPTH-1:0] pend;
    logic             wr_ok;

    assign wr_ok = wr_en && !(ZERO_REG && (wr_addr == AW'(REG_ZERO)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .issue_en_i   (issue_en),
        .issue_addr_i (issue_addr),
        .flush_i      (flush),
        .pend_o       (pend),
        .sb_empty_o   (sb_empty)
    );

    // A same-cycle writeback both supplies the data and retires the hazard on that port.
    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic          is_zero;
        logic          hit;

        assign addr    = rd_addr[k*AW +: AW];
        assign is_zero = ZERO_REG && (addr == AW'(REG_ZERO));
        assign hit     = BYPASS && wr_en && (wr_addr == addr);

        assign rd_data[k*DW +: DW] = is_zero ? '0 : (hit ? wr_data : mem_q[addr]);
        assign rd_pending[k]       = !is_zero && pend[addr] && !hit;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomised checks of regfile_sb: a default 2-port bypassing instance
// and a 4-port, 16-entry, 16-bit instance without bypass.
module tb_regfile_sb;

    logic clk;
    logic rst_n;

    logic        a_wr_en, a_issue_en, a_flush;
    logic [4:0]  a_wr_addr, a_issue_addr;
    logic [31:0] a_wr_data;
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_pending;
    logic        a_sb_empty;

    logic        b_wr_en, b_issue_en, b_flush;
    logic [3:0]  b_wr_addr, b_issue_addr;
    logic [15:0] b_wr_data;
    logic [15:0] b_rd_addr;
    logic [63:0] b_rd_data;
    logic [3:0]  b_rd_pending;
    logic        b_sb_empty;

    regfile_sb u_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (a_wr_en),
        .wr_addr    (a_wr_addr),
        .wr_data    (a_wr_data),
        .issue_en   (a_issue_en),
        .issue_addr (a_issue_addr),
        .flush      (a_flush),
        .rd_addr    (a_rd_addr),
        .rd_data    (a_rd_data),
        .rd_pending (a_rd_pending),
        .sb_empty   (a_sb_empty)
    );

    regfile_sb #(
        .DW(16), .DEPTH(16), .AW(4), .NR(4), .ZERO_REG(1'b1), .BYPASS(1'b0)
    ) u_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (b_wr_en),
        .wr_addr    (b_wr_addr),
        .wr_data    (b_wr_data),
        .issue_en   (b_issue_en),
        .issue_addr (b_issue_addr),
        .flush      (b_flush),
        .rd_addr    (b_rd_addr),
        .rd_data    (b_rd_data),
        .rd_pending (b_rd_pending),
        .sb_empty   (b_sb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    logic [15:0] mdl_mem [16];
    logic        mdl_pend [16];

    task automatic push_exp(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic check_out(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL underflow: observed %h with no expected value queued", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a_wr_en = 1'b0; a_issue_en = 1'b0; a_flush = 1'b0;
        b_wr_en = 1'b0; b_issue_en = 1'b0; b_flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
        a_wr_addr = '0; a_wr_data = '0; a_issue_addr = '0; a_rd_addr = '0;
        b_wr_addr = '0; b_wr_data = '0; b_issue_addr = '0; b_rd_addr = '0;
        a_rd_addr = {5'd6, 5'd5};
        push_exp("reset_a_data", 64'h0);
        push_exp("reset_a_empty", 64'h1);
        push_exp("reset_b_empty", 64'h1);
        repeat (2) @(posedge clk);
        #1;
        check_out(a_rd_data);
        check_out(64'(a_sb_empty));
        check_out(64'(b_sb_empty));
        rst_n = 1'b1;

        // Test 1: write r5, issue r6, then asynchronous reset mid-cycle.
        a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF;
        a_issue_en = 1'b1; a_issue_addr = 5'd6;
        step();
        idle_all();
        push_exp("t1_r5_data", {32'h0, 32'hDEADBEEF});
        push_exp("t1_pending", 64'h2);
        push_exp("t1_empty", 64'h0);
        #1;
        check_out(a_rd_data);
        check_out(64'(a_rd_pending));
        check_out(64'(a_sb_empty));
        #2 rst_n = 1'b0;
        push_exp("t1_async_data", 64'h0);
        push_exp("t1_async_pending", 64'h0);
        push_exp("t1_async_empty", 64'h1);
        #1;
        check_out(a_rd_data);
        check_out(64'(a_rd_pending));
        check_out(64'(a_sb_empty));
        step();
        rst_n = 1'b1;

        // Test 2: writes and issues to r0 are ignored.
        a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'hFFFFFFFF;
        a_issue_en = 1'b1; a_issue_addr = 5'd0;
        a_rd_addr = {5'd0, 5'd0};
        push_exp("t2_same_data", 64'h0);
        push_exp("t2_same_pending", 64'h0);
        push_exp("t2_same_empty", 64'h1);
        #1;
        check_out(a_rd_data);
        check_out(64'(a_rd_pending));
        check_out(64'(a_sb_empty));
        step();
        idle_all();
        push_exp("t2_after_data", 64'h0);
        push_exp("t2_after_pending", 64'h0);
        push_exp("t2_after_empty", 64'h1);
        #1;
        check_out(a_rd_data);
        check_out(64'(a_rd_pending));
        check_out(64'(a_sb_empty));

        // Test 3: bypass on A, no bypass on B.
        a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h12345678;
        b_wr_en = 1'b1; b_wr_addr = 4'd7; b_wr_data = 16'h1234;
        step();
        a_wr_data = 32'hCAFEF00D;
        b_wr_data = 16'hF00D;
        a_rd_addr = {5'd7, 5'd7};
        b_rd_addr = {4{4'd7}};
        push_exp("t3_bypass_a", {32'hCAFEF00D, 32'hCAFEF00D});
        push_exp("t3_nobypass_b", {4{16'h1234}});
        #1;
        check_out(a_rd_data);
        check_out(b_rd_data);
        step();
        idle_all();
        push_exp("t3_after_a", {32'hCAFEF00D, 32'hCAFEF00D});
        push_exp("t3_after_b", {4{16'hF00D}});
        #1;
        check_out(a_rd_data);
        check_out(b_rd_data);

        // Test 4: issue r9 then retire it.
        a_issue_en = 1'b1; a_issue_addr = 5'd9;
        b_issue_en = 1'b1; b_issue_addr = 4'd9;
        step();
        idle_all();
        a_rd_addr = {5'd0, 5'd9};
        b_rd_addr = {4{4'd9}};
        push_exp("t4_pending", 64'h1);
        push_exp("t4_empty", 64'h0);
        #1;
        check_out(64'(a_rd_pending));
        check_out(64'(a_sb_empty));
        a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h55;
        b_wr_en = 1'b1; b_wr_addr = 4'd9; b_wr_data = 16'h55;
        push_exp("t4_wb_pending", 64'h0);
        push_exp("t4_wb_data", 64'h55);
        push_exp("t4_wb_empty", 64'h0);
        push_exp("t4_b_wb_pending", 64'hF);
        #1;
        check_out(64'(a_rd_pending));
        check_out(a_rd_data);
        check_out(64'(a_sb_empty));
        check_out(64'(b_rd_pending));
        step();
        idle_all();
        push_exp("t4_after_empty", 64'h1);
        push_exp("t4_after_pending", 64'h0);
        push_exp("t4_b_after_pending", 64'h0);
        #1;
        check_out(64'(a_sb_empty));
        check_out(64'(a_rd_pending));
        check_out(64'(b_rd_pending));

        // Test 5: issue wins over writeback and over flush.
        a_issue_en = 1'b1; a_issue_addr = 5'd3;
        a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'h33;
        step();
        idle_all();
        a_rd_addr = {5'd4, 5'd3};
        push_exp("t5_iss_wb_pending", 64'h1);
        #1;
        check_out(64'(a_rd_pending));
        a_flush = 1'b1; a_issue_en = 1'b1; a_issue_addr = 5'd4;
        step();
        idle_all();
        push_exp("t5_flush_pending", 64'h2);
        push_exp("t5_flush_empty", 64'h0);
        #1;
        check_out(64'(a_rd_pending));
        check_out(64'(a_sb_empty));
        a_wr_en = 1'b1; a_wr_addr = 5'd4; a_wr_data = 32'h44;
        step();
        idle_all();
        push_exp("t5_final_empty", 64'h1);
        push_exp("t5_final_data", {32'h44, 32'h33});
        #1;
        check_out(64'(a_sb_empty));
        check_out(a_rd_data);

        // Test 6: random traffic on B against a reference model.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mdl_mem[i]  = '0;
            mdl_pend[i] = 1'b0;
        end
        step();
        for (int n = 0; n < 10000; n++) begin
            logic any_pend;
            b_wr_en      = 1'($urandom_range(0, 1));
            b_wr_addr    = 4'($urandom);
            b_wr_data    = 16'($urandom);
            b_issue_en   = 1'($urandom_range(0, 1));
            b_issue_addr = 4'($urandom);
            b_flush      = ($urandom_range(0, 15) == 0);
            b_rd_addr    = 16'($urandom);
            for (int k = 0; k < 4; k++) begin
                logic [3:0] ra;
                ra = b_rd_addr[k*4 +: 4];
                push_exp($sformatf("rnd_data%0d", k), (ra == 4'd0) ? 64'h0 : 64'(mdl_mem[ra]));
                push_exp($sformatf("rnd_pend%0d", k), (ra == 4'd0) ? 64'h0 : 64'(mdl_pend[ra]));
            end
            any_pend = 1'b0;
            for (int i = 0; i < 16; i++) any_pend = any_pend | mdl_pend[i];
            push_exp("rnd_empty", 64'(!any_pend));
            #1;
            for (int k = 0; k < 4; k++) begin
                check_out(64'(b_rd_data[k*16 +: 16]));
                check_out(64'(b_rd_pending[k]));
            end
            check_out(64'(b_sb_empty));
            @(posedge clk);
            if (b_wr_en && (b_wr_addr != 4'd0)) mdl_mem[b_wr_addr] = b_wr_data;
            for (int i = 0; i < 16; i++) begin
                if (b_issue_en && (b_issue_addr == 4'(i)) && (i != 0)) mdl_pend[i] = 1'b1;
                else if (b_flush) mdl_pend[i] = 1'b0;
                else if (b_wr_en && (b_wr_addr == 4'(i))) mdl_pend[i] = 1'b0;
            end
            #1;
        end
        idle_all();

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL leftover: observed %0d queued expectations expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
